// File: rtl/mem2wb8_bridge.sv
// mem2wb8_bridge: turns a 64-bit req/we/addr/be/wdata memory port into
// 8-bit classic Wishbone beats, one beat per enabled lane, with a bus timeout.
module mem2wb8_bridge #(
  parameter int unsigned WB_AW   = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [31:0]      i_addr,
  input  logic [7:0]       i_be,
  input  logic [63:0]      i_wdata,
  output logic             o_ready,
  output logic             o_done,
  output logic             o_err,
  output logic [63:0]      o_rdata,
  output logic [WB_AW-1:0] o_wb_adr,
  output logic [7:0]       o_wb_dat,
  output logic             o_wb_we,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  input  logic [7:0]       i_wb_dat,
  input  logic             i_wb_ack
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [28:0]        addr_q, addr_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [7:0]         mask_q, mask_d;
  logic [2:0]         lane_q, lane_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [63:0]        rdata_q, rdata_d;
  logic [WB_AW-1:0]   wb_adr_q, wb_adr_d;
  logic [7:0]         wb_dat_q, wb_dat_d;
  logic               wb_we_q, wb_we_d;
  logic               wb_cyc_q, wb_cyc_d;

  // Byte offset within the 64-bit word is irrelevant: the lane comes from i_be.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_addr[2:0];

  // Index of the lowest set bit of a lane mask.
  function automatic logic [2:0] lowest_lane(input logic [7:0] m);
    logic [2:0] l;
    l = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) l = 3'(i);
    end
    return l;
  endfunction

  logic [7:0] acc_mask;
  logic [2:0] acc_lane;
  logic [2:0] gap_lane;
  logic [7:0] remain;
  logic       expired;

  // Next-state and next-output computation.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    wb_adr_d = wb_adr_q;
    wb_dat_d = wb_dat_q;
    wb_we_d  = wb_we_q;
    wb_cyc_d = wb_cyc_q;

    // Reads only ever fetch the lowest enabled lane.
    acc_mask = i_we ? i_be : (i_be & (~i_be + 8'd1));
    acc_lane = lowest_lane(acc_mask);
    gap_lane = lowest_lane(mask_q);
    remain   = mask_q & ~(8'd1 << lane_q);
    expired  = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);

    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          we_d    = i_we;
          addr_d  = i_addr[31:3];
          wdata_d = i_wdata;
          mask_d  = acc_mask;
          if (acc_mask != 8'd0) begin
            state_d  = ACCESS;
            lane_d   = acc_lane;
            cnt_d    = '0;
            wb_cyc_d = 1'b1;
            wb_we_d  = i_we;
            wb_adr_d = WB_AW'({i_addr[31:3], acc_lane});
            wb_dat_d = i_wdata[{acc_lane, 3'b000} +: 8];
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (i_wb_ack) begin
          mask_d   = remain;
          wb_cyc_d = 1'b0;
          if (!we_q) rdata_d = {8{i_wb_dat}};
          if (remain != 8'd0) begin
            state_d = GAP;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (expired) begin
          mask_d   = 8'd0;
          wb_cyc_d = 1'b0;
          if (!we_q) rdata_d = 64'hFFFF_FFFF_FFFF_FFFF;
          err_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d  = ACCESS;
        lane_d   = gap_lane;
        cnt_d    = '0;
        wb_cyc_d = 1'b1;
        wb_adr_d = WB_AW'({addr_q, gap_lane});
        wb_dat_d = wdata_q[{gap_lane, 3'b000} +: 8];
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      lane_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      wb_we_q  <= 1'b0;
      wb_cyc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      wb_we_q  <= wb_we_d;
      wb_cyc_q <= wb_cyc_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_rdata  = rdata_q;
  assign o_wb_adr = wb_adr_q;
  assign o_wb_dat = wb_dat_q;
  assign o_wb_we  = wb_we_q;
  assign o_wb_cyc = wb_cyc_q;
  assign o_wb_stb = wb_cyc_q;

endmodule

// File: tb/tb_mem2wb8_bridge.sv
// Directed bench for mem2wb8_bridge (WB_AW=6, TIMEOUT=4).
module tb_mem2wb8_bridge;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [7:0]  i_be;
  logic [63:0] i_wdata;
  logic        o_ready;
  logic        o_done;
  logic        o_err;
  logic [63:0] o_rdata;
  logic [5:0]  o_wb_adr;
  logic [7:0]  o_wb_dat;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [7:0]  i_wb_dat;
  logic        i_wb_ack;

  int n_chk  = 0;
  int n_fail = 0;

  mem2wb8_bridge #(.WB_AW(6), .TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_we     (i_we),
    .i_addr   (i_addr),
    .i_be     (i_be),
    .i_wdata  (i_wdata),
    .o_ready  (o_ready),
    .o_done   (o_done),
    .o_err    (o_err),
    .o_rdata  (o_rdata),
    .o_wb_adr (o_wb_adr),
    .o_wb_dat (o_wb_dat),
    .o_wb_we  (o_wb_we),
    .o_wb_cyc (o_wb_cyc),
    .o_wb_stb (o_wb_stb),
    .i_wb_dat (i_wb_dat),
    .i_wb_ack (i_wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic present(input logic we, input logic [31:0] addr, input logic [7:0] be,
                         input logic [63:0] wdata);
    i_req   = 1'b1;
    i_we    = we;
    i_addr  = addr;
    i_be    = be;
    i_wdata = wdata;
  endtask

  // Single-lane write acked on its first strobe; accept at the edge following the call.
  task automatic single_write(input string pfx);
    present(1'b1, 32'h40, 8'h01, 64'h1111_2222_3333_44A5);
    chk1({pfx, "_ready_before"}, o_ready, 1'b1);
    tick();
    i_req = 1'b0;
    chk1({pfx, "_cyc"}, o_wb_cyc, 1'b1);
    chk1({pfx, "_stb"}, o_wb_stb, 1'b1);
    chk1({pfx, "_we"}, o_wb_we, 1'b1);
    chk({pfx, "_adr"}, 64'(o_wb_adr), 64'h0);
    chk({pfx, "_dat"}, 64'(o_wb_dat), 64'hA5);
    chk1({pfx, "_ready_busy"}, o_ready, 1'b0);
    chk1({pfx, "_done_early"}, o_done, 1'b0);
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    chk1({pfx, "_cyc_drop"}, o_wb_cyc, 1'b0);
    chk1({pfx, "_done"}, o_done, 1'b1);
    chk1({pfx, "_err"}, o_err, 1'b0);
    chk1({pfx, "_ready_in_done"}, o_ready, 1'b0);
    tick();
    chk1({pfx, "_done_pulse"}, o_done, 1'b0);
    chk1({pfx, "_ready_after"}, o_ready, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    i_req    = 1'b0;
    i_we     = 1'b0;
    i_addr   = 32'h0;
    i_be     = 8'h0;
    i_wdata  = 64'h0;
    i_wb_dat = 8'h0;
    i_wb_ack = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk1("rst_ready", o_ready, 1'b1);
    chk1("rst_done", o_done, 1'b0);
    chk1("rst_err", o_err, 1'b0);
    chk("rst_rdata", o_rdata, 64'h0);
    chk1("rst_cyc", o_wb_cyc, 1'b0);
    chk1("rst_stb", o_wb_stb, 1'b0);
    chk1("rst_we", o_wb_we, 1'b0);
    chk("rst_adr", 64'(o_wb_adr), 64'h0);
    chk("rst_dat", 64'(o_wb_dat), 64'h0);

    // 1: single-lane write
    single_write("t1");

    // 2: two-lane write, lanes 0 then 7, addr bits [5:3]=3'b101
    present(1'b1, 32'h28, 8'h81, 64'h3C00_0000_0000_005A);
    tick();
    i_req = 1'b0;
    chk1("t2_b0_cyc", o_wb_cyc, 1'b1);
    chk("t2_b0_adr", 64'(o_wb_adr), 64'h28);
    chk("t2_b0_dat", 64'(o_wb_dat), 64'h5A);
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    chk1("t2_gap_cyc", o_wb_cyc, 1'b0);
    chk1("t2_gap_stb", o_wb_stb, 1'b0);
    chk1("t2_gap_done", o_done, 1'b0);
    tick();
    chk1("t2_b1_cyc", o_wb_cyc, 1'b1);
    chk("t2_b1_adr", 64'(o_wb_adr), 64'h2F);
    chk("t2_b1_dat", 64'(o_wb_dat), 64'h3C);
    chk1("t2_b1_we", o_wb_we, 1'b1);
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    chk1("t2_done", o_done, 1'b1);
    chk1("t2_err", o_err, 1'b0);
    chk1("t2_cyc_drop", o_wb_cyc, 1'b0);
    tick();
    chk1("t2_done_pulse", o_done, 1'b0);
    chk1("t2_ready", o_ready, 1'b1);

    // 3: read with all lanes enabled fetches lane 0 only
    present(1'b0, 32'h0, 8'hFF, 64'h0);
    i_wb_dat = 8'h7E;
    tick();
    i_req = 1'b0;
    chk1("t3_cyc", o_wb_cyc, 1'b1);
    chk1("t3_we", o_wb_we, 1'b0);
    chk("t3_adr", 64'(o_wb_adr), 64'h0);
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    i_wb_dat = 8'h00;
    chk1("t3_done", o_done, 1'b1);
    chk1("t3_err", o_err, 1'b0);
    chk1("t3_cyc_drop", o_wb_cyc, 1'b0);
    chk("t3_rdata", o_rdata, 64'h7E7E_7E7E_7E7E_7E7E);
    tick();
    chk1("t3_ready", o_ready, 1'b1);
    chk1("t3_no_second_beat", o_wb_cyc, 1'b0);
    chk("t3_rdata_held", o_rdata, 64'h7E7E_7E7E_7E7E_7E7E);

    // 4: read lane 2 never acked -> timeout after 4 strobe cycles
    present(1'b0, 32'h10, 8'h04, 64'h0);
    tick();
    i_req = 1'b0;
    chk("t4_adr", 64'(o_wb_adr), 64'h12);
    for (int k = 0; k < 4; k++) begin
      chk1($sformatf("t4_cyc_%0d", k), o_wb_cyc, 1'b1);
      chk1($sformatf("t4_nodone_%0d", k), o_done, 1'b0);
      tick();
    end
    chk1("t4_cyc_drop", o_wb_cyc, 1'b0);
    chk1("t4_done", o_done, 1'b1);
    chk1("t4_err", o_err, 1'b1);
    chk("t4_rdata", o_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    i_wb_ack = 1'b1;
    i_wb_dat = 8'h55;
    tick();
    i_wb_ack = 1'b0;
    chk1("t4_late_done", o_done, 1'b0);
    chk1("t4_late_err", o_err, 1'b0);
    chk1("t4_late_cyc", o_wb_cyc, 1'b0);
    chk("t4_late_rdata", o_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk1("t4_ready", o_ready, 1'b1);

    // 5: write with no lanes enabled completes without a bus cycle
    present(1'b1, 32'h8, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
    tick();
    i_req = 1'b0;
    chk1("t5_cyc", o_wb_cyc, 1'b0);
    chk1("t5_done", o_done, 1'b1);
    chk1("t5_err", o_err, 1'b0);
    chk("t5_rdata", o_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk1("t5_done_pulse", o_done, 1'b0);
    chk1("t5_ready", o_ready, 1'b1);

    // 6: reset during the second beat of a 3-lane write
    present(1'b1, 32'h0, 8'h07, 64'h0000_0000_0033_2211);
    tick();
    i_req = 1'b0;
    chk("t6_b0_dat", 64'(o_wb_dat), 64'h11);
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    tick();
    chk1("t6_b1_cyc", o_wb_cyc, 1'b1);
    chk("t6_b1_dat", 64'(o_wb_dat), 64'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("t6_rst_cyc", o_wb_cyc, 1'b0);
    chk1("t6_rst_stb", o_wb_stb, 1'b0);
    chk1("t6_rst_ready", o_ready, 1'b1);
    chk1("t6_rst_done", o_done, 1'b0);
    chk("t6_rst_rdata", o_rdata, 64'h0);
    tick();
    chk1("t6_quiet_done", o_done, 1'b0);
    chk1("t6_quiet_cyc", o_wb_cyc, 1'b0);
    single_write("t6_again");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
